// File: rtl/taxi_axil_wrr_arbiter.sv
// rtl/taxi_axil_wrr_arbiter.sv - weighted round-robin req/ack/grant arbiter
// Optional grant watchdog enabled by defining TAXI_WRR_ARB_TIMEOUT_EN.
module taxi_axil_wrr_arbiter #(
  parameter int PORTS    = 4,
  parameter int WEIGHT_W = 4,
  parameter int TIMEOUT  = 1024,
  localparam int IDX_W   = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PORTS*WEIGHT_W-1:0] cfg_weight,
  input  logic [PORTS-1:0]          req,
  input  logic [PORTS-1:0]          ack,
  output logic [PORTS-1:0]          grant,
  output logic                      grant_valid,
  output logic [IDX_W-1:0]          grant_index,
  output logic                      timeout_event
);

  localparam logic [IDX_W:0] PORTS_L = (IDX_W+1)'(PORTS);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANTED = 1'b1} state_t;

  state_t              r_state, w_state_next;
  logic [WEIGHT_W-1:0] r_credit [PORTS];
  logic [WEIGHT_W-1:0] w_credit_next [PORTS];
  logic [WEIGHT_W-1:0] w_weight [PORTS];
  logic [IDX_W-1:0]    r_ptr, w_ptr_next;
  logic [PORTS-1:0]    r_grant, w_grant_next;
  logic                r_grant_valid, w_grant_valid_next;
  logic [IDX_W-1:0]    r_grant_index, w_grant_index_next;

  logic [PORTS-1:0]    w_eligible, w_cand;
  logic                w_reload, w_found, w_ack, w_timeout;
  logic [IDX_W-1:0]    w_pick, w_idx_inc;
  logic [IDX_W:0]      w_scan;
  logic [WEIGHT_W-1:0] w_cur_credit, w_dec_credit;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      w_weight[i]   = (cfg_weight[i*WEIGHT_W +: WEIGHT_W] == '0) ? WEIGHT_W'(1)
                                                                  : cfg_weight[i*WEIGHT_W +: WEIGHT_W];
      w_eligible[i] = req[i] && (r_credit[i] != '0);
    end
  end

  // An exhausted round with pending requests reloads credits and selects in the same cycle.
  assign w_reload = (w_eligible == '0) && (req != '0);
  assign w_cand   = w_reload ? req : w_eligible;

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_scan  = '0;
    for (int k = 0; k < PORTS; k++) begin
      w_scan = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_scan >= PORTS_L) w_scan = w_scan - PORTS_L;
      if (!w_found && w_cand[w_scan[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_scan[IDX_W-1:0];
      end
    end
  end

  assign w_ack        = (r_state == ST_GRANTED) && ack[r_grant_index];
  assign w_idx_inc    = (r_grant_index == IDX_W'(PORTS-1)) ? '0 : r_grant_index + 1'b1;
  assign w_cur_credit = r_credit[r_grant_index];
  assign w_dec_credit = (w_timeout || w_cur_credit == '0) ? '0 : w_cur_credit - 1'b1;

`ifdef TAXI_WRR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_timeout_event;

  assign w_timeout = (r_state == ST_GRANTED) && !w_ack && (r_tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt       <= '0;
      r_timeout_event <= 1'b0;
    end else begin
      r_timeout_event <= w_timeout;
      r_tmo_cnt       <= (r_state == ST_IDLE) ? '0 : r_tmo_cnt + 1'b1;
    end
  end

  assign timeout_event = r_timeout_event;
`else
  assign w_timeout     = 1'b0;
  assign timeout_event = (TIMEOUT < 0);
`endif

  always_comb begin
    w_state_next       = r_state;
    w_grant_next       = r_grant;
    w_grant_valid_next = r_grant_valid;
    w_grant_index_next = r_grant_index;
    w_ptr_next         = r_ptr;
    for (int i = 0; i < PORTS; i++) w_credit_next[i] = r_credit[i];
    case (r_state)
      ST_IDLE: begin
        if (req != '0) begin
          if (w_reload) begin
            for (int i = 0; i < PORTS; i++) w_credit_next[i] = w_weight[i];
          end
          w_grant_next         = '0;
          w_grant_next[w_pick] = 1'b1;
          w_grant_valid_next   = 1'b1;
          w_grant_index_next   = w_pick;
          w_state_next         = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        if (w_ack || w_timeout) begin
          w_credit_next[r_grant_index] = w_dec_credit;
          w_ptr_next         = (w_dec_credit == '0) ? w_idx_inc : r_grant_index;
          w_grant_next       = '0;
          w_grant_valid_next = 1'b0;
          w_state_next       = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_index <= '0;
      for (int i = 0; i < PORTS; i++) r_credit[i] <= '0;
    end else begin
      r_state       <= w_state_next;
      r_ptr         <= w_ptr_next;
      r_grant       <= w_grant_next;
      r_grant_valid <= w_grant_valid_next;
      r_grant_index <= w_grant_index_next;
      for (int i = 0; i < PORTS; i++) r_credit[i] <= w_credit_next[i];
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_index = r_grant_index;

endmodule

// File: tb/tb_taxi_axil_wrr_arbiter.sv
// tb/tb_taxi_axil_wrr_arbiter.sv - self-checking bench for taxi_axil_wrr_arbiter
// Define TAXI_WRR_ARB_TIMEOUT_EN to exercise the watchdog scenario.
module tb_taxi_axil_wrr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_weight = 16'h1111;
  logic [3:0]  req = 4'h0;
  logic [3:0]  ack = 4'h0;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_index;
  logic        timeout_event;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] m_credit [4];
  int         m_ptr;

  always #5 clk = ~clk;

  taxi_axil_wrr_arbiter #(.PORTS(4), .WEIGHT_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .cfg_weight(cfg_weight), .req(req), .ack(ack),
    .grant(grant), .grant_valid(grant_valid), .grant_index(grant_index),
    .timeout_event(timeout_event)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'h0;
    ack = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < 4; i++) m_credit[i] = 4'h0;
  endtask

  // Reference: a request set picks the first port with credit starting at the
  // priority pointer; an empty round refills every port with max(weight,1).
  function automatic int model_pick(input logic [3:0] r, input logic [15:0] w);
    bit any = 0;
    for (int i = 0; i < 4; i++) if (r[i] && m_credit[i] > 0) any = 1;
    if (!any && r != 0)
      for (int i = 0; i < 4; i++) m_credit[i] = (w[i*4 +: 4] == 0) ? 4'd1 : w[i*4 +: 4];
    for (int k = 0; k < 4; k++) begin
      int p = (m_ptr + k) % 4;
      if (r[p] && m_credit[p] > 0) return p;
    end
    return -1;
  endfunction

  function automatic void model_done(input int p);
    if (m_credit[p] > 0) m_credit[p] = m_credit[p] - 4'd1;
    m_ptr = (m_credit[p] == 0) ? (p + 1) % 4 : p;
  endfunction

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if ({grant_valid, grant, grant_index, timeout_event} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: valid=%b grant=%b index=%0d tmo=%b, required all zero",
                 c, grant_valid, grant, grant_index, timeout_event);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    cfg_weight = 16'h1111;
    req = 4'hF;
    for (int n = 0; n < 8; n++) begin
      tick();
      n_checks++;
      if ({grant_valid, grant_index} !== {1'b1, 2'(exp_seq[n])}) begin
        n_fail++;
        $display("FAIL rr_grant #%0d: valid=%b index=%0d, required valid=1 index=%0d",
                 n, grant_valid, grant_index, exp_seq[n]);
      end
      ack = 4'(1 << exp_seq[n]);
      tick();
      ack = 4'h0;
      n_checks++;
      if (grant_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_idle_gap #%0d: valid=%b, required 0", n, grant_valid);
      end
    end
    req = 4'h0;
  endtask

  task automatic test_weighted();
    int exp_seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    do_reset();
    cfg_weight = 16'h1113;
    req = 4'b0011;
    for (int n = 0; n < 8; n++) begin
      tick();
      n_checks++;
      if ({grant_valid, grant, grant_index} !== {1'b1, 4'(1 << exp_seq[n]), 2'(exp_seq[n])}) begin
        n_fail++;
        $display("FAIL wrr_grant #%0d: valid=%b grant=%b index=%0d, required index=%0d",
                 n, grant_valid, grant, grant_index, exp_seq[n]);
      end
      ack = 4'(1 << exp_seq[n]);
      tick();
      ack = 4'h0;
    end
    req = 4'h0;
  endtask

  task automatic test_ack_other();
    do_reset();
    cfg_weight = 16'h1111;
    req = 4'b0100;
    tick();
    n_checks++;
    if ({grant_valid, grant, grant_index} !== {1'b1, 4'b0100, 2'd2}) begin
      n_fail++;
      $display("FAIL ackx_first: valid=%b grant=%b index=%0d, required 1/0100/2",
               grant_valid, grant, grant_index);
    end
    req = 4'h0;
    ack = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if ({grant_valid, grant} !== {1'b1, 4'b0100}) begin
        n_fail++;
        $display("FAIL ackx_hold %0d: valid=%b grant=%b, required 1/0100", c, grant_valid, grant);
      end
    end
    ack = 4'b0100;
    tick();
    ack = 4'h0;
    req = 4'b0100;
    n_checks++;
    if ({grant_valid, grant} !== 5'b0) begin
      n_fail++;
      $display("FAIL ackx_release: valid=%b grant=%b, required 0/0000", grant_valid, grant);
    end
    tick();
    n_checks++;
    if ({grant_valid, grant_index} !== {1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL ackx_regrant: valid=%b index=%0d, required 1/2", grant_valid, grant_index);
    end
    ack = 4'b0100;
    req = 4'h0;
    tick();
    ack = 4'h0;
  endtask

  task automatic test_async_reset();
    do_reset();
    cfg_weight = 16'h1111;
    req = 4'b0001;
    tick();
    n_checks++;
    if (grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: valid=%b, required 1", grant_valid);
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({grant_valid, grant, grant_index} !== 7'b0) begin
      n_fail++;
      $display("FAIL arst_drop: valid=%b grant=%b index=%0d, required all zero before edge",
               grant_valid, grant, grant_index);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b1000;
    tick();
    n_checks++;
    if ({grant_valid, grant, grant_index} !== {1'b1, 4'b1000, 2'd3}) begin
      n_fail++;
      $display("FAIL arst_after: valid=%b grant=%b index=%0d, required 1/1000/3",
               grant_valid, grant, grant_index);
    end
    ack = 4'b1000;
    req = 4'h0;
    tick();
    ack = 4'h0;
  endtask

`ifdef TAXI_WRR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    cfg_weight = 16'h1111;
    req = 4'b0010;
    tick();
    n_checks++;
    if ({grant_valid, grant_index} !== {1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL tmo_grant: valid=%b index=%0d, required 1/1", grant_valid, grant_index);
    end
    req = 4'b0011;
    for (int c = 1; c < 16; c++) begin
      tick();
      n_checks++;
      if ({grant_valid, timeout_event} !== 2'b10) begin
        n_fail++;
        $display("FAIL tmo_wait cycle %0d: valid=%b tmo=%b, required 1/0", c, grant_valid, timeout_event);
      end
    end
    tick();
    n_checks++;
    if ({grant_valid, timeout_event} !== 2'b01) begin
      n_fail++;
      $display("FAIL tmo_fire: valid=%b tmo=%b, required 0/1", grant_valid, timeout_event);
    end
    tick();
    n_checks++;
    if ({grant_valid, timeout_event, grant_index} !== {2'b10, 2'd0}) begin
      n_fail++;
      $display("FAIL tmo_next: valid=%b tmo=%b index=%0d, required 1/0/0",
               grant_valid, timeout_event, grant_index);
    end
    ack = 4'b0001;
    req = 4'h0;
    tick();
    ack = 4'h0;
  endtask
`else
  task automatic test_hold();
    do_reset();
    cfg_weight = 16'h1111;
    req = 4'b0010;
    tick();
    req = 4'h0;
    for (int c = 0; c < 40; c++) begin
      n_checks++;
      if ({grant_valid, grant, timeout_event} !== 6'b1_0010_0) begin
        n_fail++;
        $display("FAIL hold cycle %0d: valid=%b grant=%b tmo=%b, required 1/0010/0",
                 c, grant_valid, grant, timeout_event);
      end
      tick();
    end
    ack = 4'b0010;
    tick();
    ack = 4'h0;
  endtask
`endif

  task automatic test_random();
    int         p;
    int         hold;
    logic [3:0] r;
    logic [3:0] g;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = 4'h0;
        tick();
        n_checks++;
        if (grant_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_noreq #%0d: valid=%b, required 0", n, grant_valid);
        end
      end
      if ($urandom_range(0, 4) == 0) cfg_weight = 16'($urandom);
      r = 4'($urandom_range(1, 15));
      req = r;
      p = model_pick(r, cfg_weight);
      g = 4'(1 << p);
      tick();
      n_checks++;
      if ({grant_valid, grant, grant_index, timeout_event} !== {1'b1, g, 2'(p), 1'b0}) begin
        n_fail++;
        $display("FAIL rand_grant #%0d: req=%b valid=%b grant=%b index=%0d, required index=%0d",
                 n, r, grant_valid, grant, grant_index, p);
      end
      hold = $urandom_range(0, 3);
      for (int c = 0; c < hold; c++) begin
        ack = 4'($urandom) & ~g;
        req = 4'($urandom);
        tick();
        n_checks++;
        if ({grant_valid, grant} !== {1'b1, g}) begin
          n_fail++;
          $display("FAIL rand_hold #%0d: valid=%b grant=%b, required 1/%b", n, grant_valid, grant, g);
        end
      end
      ack = g | 4'($urandom);
      tick();
      ack = 4'h0;
      model_done(p);
      n_checks++;
      if ({grant_valid, grant} !== 5'b0) begin
        n_fail++;
        $display("FAIL rand_release #%0d: valid=%b grant=%b, required 0/0000", n, grant_valid, grant);
      end
    end
    req = 4'h0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_weighted();
    test_ack_other();
    test_async_reset();
`ifdef TAXI_WRR_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
